text_console: RTL and testbench
===============================

// Module: text_console
// PURPOSE
//  Character-stream front end for the textmode tram. Accepts Unicode code points on a
//  valid/ready stream and writes them into tram at a hardware cursor, with text colours.
//  Handles CR/LF, line wrap, hardware scrolling via scroll_offs, clearing of the newly
//  exposed line, and full-screen clear. Sits between the CPU console register and the
//  tram write port. scroll_offs drives the textmode scroll offset directly.
// PARAMETERS
//  WORD       32  tram word width (bits)
//  ADDRW      14  tram address width (bits)
//  CIDXW       4  colour index width (bits)
//  TRAM_HRES  80  tram width (chars), >= 2
//  TRAM_VRES  30  tram height (chars), >= 2
// PORTS
//  clk          in   1      clock
//  rst_n        in   1      asynchronous, active-low reset
//  ch_valid     in   1      code point offered
//  ch_ready     out  1      code point accepted when ch_valid && ch_ready
//  ch_ucp       in   21     Unicode code point
//  colr_fg      in   CIDXW  foreground colour; sampled at handshake
//  colr_bg      in   CIDXW  background colour; sampled at handshake, also used by clears
//  clear        in   1      pulse: request full-screen clear
//  tram_we      out  1      tram write enable
//  tram_waddr   out  ADDRW  tram write address
//  tram_wdata   out  WORD   {bg[CIDXW], fg[CIDXW], zero pad, ucp[20:0]}
//  scroll_offs  out  ADDRW  tram address of top display line
//  cur_x        out  ADDRW  cursor column, 0..TRAM_HRES-1
//  cur_y        out  ADDRW  cursor row relative to display top, 0..TRAM_VRES-1
// BEHAVIOUR
//  - All outputs registered. Reset (async assert, sync deassert): state IDLE, all outputs
//    0, clear_pend 0. tram contents untouched; software issues clear after reset.
//  - ch_ready = 1 only in IDLE with clear_pend 0; goes 1 the first cycle after rst_n rises.
//  - clear latched into clear_pend in any state; serviced from IDLE with priority over
//    ch_valid. Later clear pulses during CLEAR_ALL are absorbed.
//  - Address: cell = (line_base + cur_x); line_base = scroll_offs + cur_y*TRAM_HRES, kept
//    incrementally. All adds wrap mod TOTAL = TRAM_HRES*TRAM_VRES (compare-and-subtract,
//    no multiplier, no modulo operator).
//  - States: IDLE, PUT, NEWLINE, CLR_LINE, CLR_ALL.
//  - IDLE + handshake (cycle T), printable ucp (not 0x0A/0x0D): PUT; tram_we=1 at T+1 with
//    cell address/data. Then if cur_x<HRES-1: cur_x+1, back to IDLE (ready at T+2);
//    else cur_x=0, NEWLINE (auto-wrap).
//  - 0x0D: cur_x=0, no write, IDLE next cycle. 0x0A: cur_x=0, NEWLINE.
//  - NEWLINE (1 cycle): if cur_y<VRES-1: cur_y+1, line_base+=HRES, IDLE. Else scroll:
//    scroll_offs+=HRES (wrap to 0 at TOTAL), cur_y stays VRES-1, line_base = old
//    scroll_offs (the exposed line), go CLR_LINE.
//  - CLR_LINE: HRES consecutive cycles of tram_we, ucp 0x20, colr_bg of last handshake
//    (fg=bg), addresses line_base..line_base+HRES-1; then IDLE.
//  - CLR_ALL: TOTAL cycles of writes, addr 0..TOTAL-1, ucp 0x20; scroll_offs, cur_x,
//    cur_y, line_base = 0 at entry; clear_pend cleared on entry; then IDLE.
//  - tram_we is 0 in every cycle not listed above; tram_waddr/wdata hold last value.
//  - ch_ucp above 0x10FFFF written as-is (no filtering).
// STRUCTURE
//  - Shared package/header: tram word field positions (UCP_W=21, fg/bg slices), CHAR_SPACE,
//    CHAR_LF, CHAR_CR, state encoding.
//  - One sub-module natural: tram_addr_wrap (combinational a+b mod TOTAL, b<TOTAL), reused
//    for cell, line_base and scroll_offs updates. Rest is a single FSM plus counters.
// TESTING (HRES=4, VRES=3, TOTAL=12 unless noted)
//  - Reset, then send 'A'(0x41) fg=2 bg=1 -> ready drops 1 cycle; one write addr 0,
//    wdata {1,2,..,0x41}; cur_x=1, ready again 2 cycles after handshake.
//  - Send 5 printables -> writes addr 0,1,2,3 then auto-wrap, 5th at addr 4; cur=(1,1).
//  - Send LF x3 from row 0 -> row 2, then scroll: scroll_offs=4, CLR_LINE writes addr 0..3
//    with 0x20; cur=(0,2); ready low exactly 1+4 cycles.
//  - Repeat scrolling 3 times -> scroll_offs sequence 4,8,0 (wrap); cleared lines 0,4,8.
//  - Pulse clear mid-CLR_LINE -> line finishes, then 12 writes addr 0..11, all outputs
//    state 0, ready after; ch_valid held high throughout is not accepted until then.
//  - Drop rst_n mid-CLR_ALL -> tram_we, scroll_offs, cursor 0 immediately (async);
//    ch_ready 1 the cycle after rst_n rises.

Source files
------------

// File: rtl/text_console_pkg.sv
// Shared definitions for the text console: tram word layout, control characters, FSM states.
// A tram word is {bg, fg, zero pad, ucp}: the code point sits in the low UCP_W bits,
// fg directly above the pad, bg in the top CIDXW bits (widths come from the top's params).
package text_console_pkg;

  localparam int UCP_W   = 21;
  localparam int UCP_LSB = 0;

  localparam logic [UCP_W-1:0] CHAR_SPACE = 21'h00020;
  localparam logic [UCP_W-1:0] CHAR_LF    = 21'h0000A;
  localparam logic [UCP_W-1:0] CHAR_CR    = 21'h0000D;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUT      = 3'd1,
    ST_NEWLINE  = 3'd2,
    ST_CLR_LINE = 3'd3,
    ST_CLR_ALL  = 3'd4
  } state_t;

endpackage

// File: rtl/text_console_addr_wrap.sv
// Combinational tram address adder: y = (a + b) mod TOTAL, assuming a, b < TOTAL.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; single compare-and-subtract, no divider.
module tram_addr_wrap #(
  parameter int ADDRW = 14,
  parameter int TOTAL = 2400
) (
  input  logic [ADDRW-1:0] a,
  input  logic [ADDRW-1:0] b,
  output logic [ADDRW-1:0] y
);

  localparam logic [ADDRW:0] TOTAL_W = (ADDRW+1)'(TOTAL);

  logic [ADDRW:0] sum;
  logic [ADDRW:0] sum_sub;

  // Operands are both below TOTAL, so one conditional subtract brings the sum back in range
  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    sum_sub = sum - TOTAL_W;
    if (sum >= TOTAL_W) y = sum_sub[ADDRW-1:0];
    else                y = sum[ADDRW-1:0];
  end

endmodule

// File: rtl/text_console.sv
// Character stream to tram writer with cursor, CR/LF, wrap, hardware scroll and clears.
// Latency: a printable code point is written one cycle after its handshake.
// Backpressure: ch_ready is high only in IDLE with no clear pending; clears stall the stream.
module text_console
  import text_console_pkg::*;
#(
  parameter int WORD      = 32,
  parameter int ADDRW     = 14,
  parameter int CIDXW     = 4,
  parameter int TRAM_HRES = 80,
  parameter int TRAM_VRES = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ch_valid,
  output logic             ch_ready,
  input  logic [20:0]      ch_ucp,
  input  logic [CIDXW-1:0] colr_fg,
  input  logic [CIDXW-1:0] colr_bg,
  input  logic             clear,
  output logic             tram_we,
  output logic [ADDRW-1:0] tram_waddr,
  output logic [WORD-1:0]  tram_wdata,
  output logic [ADDRW-1:0] scroll_offs,
  output logic [ADDRW-1:0] cur_x,
  output logic [ADDRW-1:0] cur_y
);

  localparam int TOTAL = TRAM_HRES * TRAM_VRES;
  localparam int PAD_W = WORD - 2*CIDXW - UCP_W;

  localparam logic [ADDRW-1:0] HRES_A      = ADDRW'(TRAM_HRES);
  localparam logic [ADDRW-1:0] HRES_LAST   = ADDRW'(TRAM_HRES - 1);
  localparam logic [ADDRW-1:0] VRES_LAST   = ADDRW'(TRAM_VRES - 1);
  localparam logic [ADDRW-1:0] TOTAL_A     = ADDRW'(TOTAL);

  state_t           state;
  logic             clear_pend;
  logic [CIDXW-1:0] bg_q;        // bg of the last handshake, used for blanking
  logic [ADDRW-1:0] line_base;   // tram address of the cursor line
  logic [ADDRW-1:0] cnt;         // write counter for line / screen clears

  logic [ADDRW-1:0] cell_b;
  logic [ADDRW-1:0] cell_addr;
  logic [ADDRW-1:0] line_next;
  logic [ADDRW-1:0] scroll_next;
  logic             hs;
  logic             pend_next;

  function automatic logic [WORD-1:0] pack_word(input logic [CIDXW-1:0] bg,
                                                input logic [CIDXW-1:0] fg,
                                                input logic [UCP_W-1:0] ucp);
    pack_word = {bg, fg, {PAD_W{1'b0}}, ucp};
  endfunction

  // The line clear walks the same line_base + offset adder the cursor uses
  assign cell_b    = (state == ST_CLR_LINE) ? cnt : cur_x;
  assign hs        = ch_valid && ch_ready;
  assign pend_next = clear_pend | clear;

  tram_addr_wrap #(.ADDRW(ADDRW), .TOTAL(TOTAL)) u_cell (
    .a(line_base), .b(cell_b), .y(cell_addr)
  );

  tram_addr_wrap #(.ADDRW(ADDRW), .TOTAL(TOTAL)) u_line (
    .a(line_base), .b(HRES_A), .y(line_next)
  );

  tram_addr_wrap #(.ADDRW(ADDRW), .TOTAL(TOTAL)) u_scroll (
    .a(scroll_offs), .b(HRES_A), .y(scroll_next)
  );

  // Console FSM: handshake, cursor/scroll bookkeeping and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      clear_pend  <= 1'b0;
      bg_q        <= '0;
      line_base   <= '0;
      cnt         <= '0;
      ch_ready    <= 1'b0;
      tram_we     <= 1'b0;
      tram_waddr  <= '0;
      tram_wdata  <= '0;
      scroll_offs <= '0;
      cur_x       <= '0;
      cur_y       <= '0;
    end else begin
      tram_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clear_pend) begin
            // Full clear resets the view; the first write is issued on entry
            state       <= ST_CLR_ALL;
            clear_pend  <= 1'b0;
            ch_ready    <= 1'b0;
            scroll_offs <= '0;
            cur_x       <= '0;
            cur_y       <= '0;
            line_base   <= '0;
            tram_we     <= 1'b1;
            tram_waddr  <= '0;
            tram_wdata  <= pack_word(bg_q, bg_q, CHAR_SPACE);
            cnt         <= ADDRW'(1);
          end else begin
            clear_pend <= clear;
            ch_ready   <= !clear;
            if (hs) begin
              bg_q <= colr_bg;
              if (ch_ucp == CHAR_CR) begin
                cur_x <= '0;
              end else if (ch_ucp == CHAR_LF) begin
                cur_x    <= '0;
                state    <= ST_NEWLINE;
                ch_ready <= 1'b0;
              end else begin
                tram_we    <= 1'b1;
                tram_waddr <= cell_addr;
                tram_wdata <= pack_word(colr_bg, colr_fg, ch_ucp);
                state      <= ST_PUT;
                ch_ready   <= 1'b0;
              end
            end
          end
        end

        ST_PUT: begin
          clear_pend <= pend_next;
          if (cur_x < HRES_LAST) begin
            cur_x    <= cur_x + 1'b1;
            state    <= ST_IDLE;
            ch_ready <= !pend_next;
          end else begin
            cur_x <= '0;
            state <= ST_NEWLINE;
          end
        end

        ST_NEWLINE: begin
          clear_pend <= pend_next;
          if (cur_y < VRES_LAST) begin
            cur_y     <= cur_y + 1'b1;
            line_base <= line_next;
            state     <= ST_IDLE;
            ch_ready  <= !pend_next;
          end else begin
            // Scroll: the old top line becomes the new bottom line and gets blanked
            scroll_offs <= scroll_next;
            line_base   <= scroll_offs;
            state       <= ST_CLR_LINE;
            tram_we     <= 1'b1;
            tram_waddr  <= scroll_offs;
            tram_wdata  <= pack_word(bg_q, bg_q, CHAR_SPACE);
            cnt         <= ADDRW'(1);
          end
        end

        ST_CLR_LINE: begin
          clear_pend <= pend_next;
          if (cnt < HRES_A) begin
            tram_we    <= 1'b1;
            tram_waddr <= cell_addr;
            cnt        <= cnt + 1'b1;
          end else begin
            state    <= ST_IDLE;
            ch_ready <= !pend_next;
          end
        end

        ST_CLR_ALL: begin
          // Clear requests arriving here are already covered by this pass
          if (cnt < TOTAL_A) begin
            tram_we    <= 1'b1;
            tram_waddr <= cnt;
            cnt        <= cnt + 1'b1;
          end else begin
            state    <= ST_IDLE;
            ch_ready <= 1'b1;
          end
        end

        default: begin
          state    <= ST_IDLE;
          ch_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_console.sv
// Self-checking bench for text_console on a 4x3 tram (12 cells).
module tb_text_console;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int T  = H * V;
  localparam logic [20:0] LF = 21'h0A;
  localparam logic [20:0] CR = 21'h0D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ch_valid = 1'b0;
  logic        ch_ready;
  logic [20:0] ch_ucp = '0;
  logic [3:0]  colr_fg = '0;
  logic [3:0]  colr_bg = '0;
  logic        clear = 1'b0;
  logic        tram_we;
  logic [13:0] tram_waddr;
  logic [31:0] tram_wdata;
  logic [13:0] scroll_offs;
  logic [13:0] cur_x;
  logic [13:0] cur_y;

  text_console #(.WORD(32), .ADDRW(14), .CIDXW(4), .TRAM_HRES(H), .TRAM_VRES(V)) dut (
    .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_ucp(ch_ucp),
    .colr_fg(colr_fg), .colr_bg(colr_bg), .clear(clear), .tram_we(tram_we),
    .tram_waddr(tram_waddr), .tram_wdata(tram_wdata), .scroll_offs(scroll_offs),
    .cur_x(cur_x), .cur_y(cur_y)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Every tram write seen on the port, plus a shadow of the tram contents
  int          wr_a[$];
  logic [31:0] wr_d[$];
  logic [31:0] dut_tram [T];

  always @(negedge clk) begin
    if (tram_we) begin
      wr_a.push_back(int'(tram_waddr));
      wr_d.push_back(tram_wdata);
      if (int'(tram_waddr) < T) dut_tram[int'(tram_waddr)] = tram_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: screen position and tram image computed from the console rules
  int          m_x, m_y, m_s;
  logic [31:0] m_tram [T];
  int          e_a[$];
  logic [31:0] e_d[$];
  int          e_low;

  function automatic logic [31:0] word_of(input int bg, input int fg, input int u);
    return (bg << 28) | (fg << 24) | (u & 32'h1FFFFF);
  endfunction

  task automatic model_newline(input int bg);
    int old;
    e_low++;
    if (m_y < V-1) m_y++;
    else begin
      old = m_s;
      m_s = (m_s + H) % T;
      for (int i = 0; i < H; i++) begin
        e_a.push_back((old + i) % T);
        e_d.push_back(word_of(bg, bg, 32'h20));
        m_tram[(old + i) % T] = word_of(bg, bg, 32'h20);
        e_low++;
      end
    end
  endtask

  task automatic model_char(input int u, input int fg, input int bg);
    int a;
    e_a.delete(); e_d.delete(); e_low = 0;
    if (u == 32'h0D) m_x = 0;
    else if (u == 32'h0A) begin m_x = 0; model_newline(bg); end
    else begin
      a = (m_s + m_y*H + m_x) % T;
      e_a.push_back(a); e_d.push_back(word_of(bg, fg, u));
      m_tram[a] = word_of(bg, fg, u);
      e_low = 1;
      m_x++;
      if (m_x == H) begin m_x = 0; model_newline(bg); end
    end
  endtask

  // Offer one code point, wait for the handshake, then count cycles until ready returns
  task automatic send_char(input logic [20:0] u, input logic [3:0] f, input logic [3:0] b,
                           output int low, output int base);
    int guard;
    @(negedge clk); #1;
    base = wr_a.size();
    ch_valid = 1'b1; ch_ucp = u; colr_fg = f; colr_bg = b;
    guard = 0;
    while (!ch_ready && guard < 50) begin @(negedge clk); #1; guard++; end
    if (guard >= 50) chk("ready_timeout_in", 32'(ch_ready), 32'd1);
    @(posedge clk); #1;
    ch_valid = 1'b0;
    low = 0;
    @(negedge clk);
    while (!ch_ready && low < 100) begin low++; @(negedge clk); end
    if (low >= 100) chk("ready_timeout_out", 32'(ch_ready), 32'd1);
    #1;
  endtask

  typedef struct {
    logic [20:0] ucp;
    logic [3:0]  fg;
    logic [3:0]  bg;
    int          ex, ey, es, nwr, low, a0;
    logic [31:0] d0;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int low, base, nw, r;
    logic [20:0] u;
    logic [3:0]  f, b;

    tbl[0]  = '{21'h41, 4'd2, 4'd1, 1, 0, 0, 1, 1, 0,  32'h12000041};
    tbl[1]  = '{21'h42, 4'd2, 4'd1, 2, 0, 0, 1, 1, 1,  32'h12000042};
    tbl[2]  = '{21'h43, 4'd2, 4'd1, 3, 0, 0, 1, 1, 2,  32'h12000043};
    tbl[3]  = '{21'h44, 4'd7, 4'd6, 0, 1, 0, 1, 2, 3,  32'h67000044};
    tbl[4]  = '{21'h45, 4'd2, 4'd1, 1, 1, 0, 1, 1, 4,  32'h12000045};
    tbl[5]  = '{CR,     4'd0, 4'd0, 0, 1, 0, 0, 0, 0,  32'h0};
    tbl[6]  = '{LF,     4'd0, 4'd0, 0, 2, 0, 0, 1, 0,  32'h0};
    tbl[7]  = '{LF,     4'd5, 4'd3, 0, 2, 4, 4, 5, 0,  32'h33000020};
    tbl[8]  = '{LF,     4'd5, 4'd3, 0, 2, 8, 4, 5, 4,  32'h33000020};
    tbl[9]  = '{LF,     4'd5, 4'd3, 0, 2, 0, 4, 5, 8,  32'h33000020};
    tbl[10] = '{21'h5A, 4'hF, 4'hE, 1, 2, 0, 1, 1, 8,  32'hEF00005A};
    tbl[11] = '{21'h1FFFFF, 4'd1, 4'd2, 2, 2, 0, 1, 1, 9, 32'h211FFFFF};
    tbl[12] = '{21'h78, 4'd2, 4'd1, 3, 2, 0, 1, 1, 10, 32'h12000078};
    tbl[13] = '{21'h79, 4'd2, 4'd1, 0, 2, 4, 5, 6, 11, 32'h12000079};

    // Reset state
    #12;
    chk("rst_ready", 32'(ch_ready), 0);
    chk("rst_we", 32'(tram_we), 0);
    chk("rst_waddr", 32'(tram_waddr), 0);
    chk("rst_wdata", tram_wdata, 0);
    chk("rst_scroll", 32'(scroll_offs), 0);
    chk("rst_xy", {16'(cur_x), 16'(cur_y)}, 0);
    @(negedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(ch_ready), 1);

    // Directed table
    for (int i = 0; i < 14; i++) begin
      send_char(tbl[i].ucp, tbl[i].fg, tbl[i].bg, low, base);
      nw = wr_a.size() - base;
      chk($sformatf("t%0d_nwr", i), 32'(nw), 32'(tbl[i].nwr));
      chk($sformatf("t%0d_low", i), 32'(low), 32'(tbl[i].low));
      chk($sformatf("t%0d_x", i), 32'(cur_x), 32'(tbl[i].ex));
      chk($sformatf("t%0d_y", i), 32'(cur_y), 32'(tbl[i].ey));
      chk($sformatf("t%0d_scroll", i), 32'(scroll_offs), 32'(tbl[i].es));
      if (tbl[i].nwr > 0 && nw > 0) begin
        chk($sformatf("t%0d_addr", i), 32'(wr_a[base]), 32'(tbl[i].a0));
        chk($sformatf("t%0d_data", i), wr_d[base], tbl[i].d0);
      end
      if (tbl[i].ucp == LF && nw == tbl[i].nwr)
        for (int k = 1; k < nw; k++) begin
          chk($sformatf("t%0d_clr_addr%0d", i, k), 32'(wr_a[base+k]), 32'(tbl[i].a0 + k));
          chk($sformatf("t%0d_clr_data%0d", i, k), wr_d[base+k], tbl[i].d0);
        end
    end

    // Clear pulsed mid line-clear, with a character held on the stream throughout
    @(negedge clk); #1;
    base = wr_a.size();
    ch_valid = 1'b1; ch_ucp = LF; colr_fg = 4'd0; colr_bg = 4'd9;
    chk("clr_ready_pre", 32'(ch_ready), 1);
    @(posedge clk); #1;
    ch_ucp = 21'h51; colr_fg = 4'd4;
    low = 0;
    while (1) begin
      @(negedge clk);
      if (ch_ready || low > 100) break;
      low++;
      #1;
      clear = (low == 2);
    end
    #1;
    clear = 1'b0;
    chk("clr_low", 32'(low), 32'(1 + H + 1 + T));
    nw = wr_a.size() - base;
    chk("clr_nwr", 32'(nw), 32'(H + T));
    if (nw == H + T) begin
      for (int k = 0; k < H + T; k++) begin
        chk($sformatf("clr_addr%0d", k), 32'(wr_a[base+k]), (k < H) ? 32'(4 + k) : 32'(k - H));
        chk($sformatf("clr_data%0d", k), wr_d[base+k], 32'h99000020);
      end
    end
    chk("clr_scroll", 32'(scroll_offs), 0);
    chk("clr_xy", {16'(cur_x), 16'(cur_y)}, 0);
    @(posedge clk); #1;
    ch_valid = 1'b0;
    @(negedge clk);
    chk("clr_q_we", 32'(tram_we), 1);
    chk("clr_q_addr", 32'(tram_waddr), 0);
    chk("clr_q_data", tram_wdata, 32'h94000051);
    @(negedge clk);
    chk("clr_q_x", 32'(cur_x), 1);
    chk("clr_q_ready", 32'(ch_ready), 1);

    // Randomized stream against the reference model
    m_x = 1; m_y = 0; m_s = 0;
    for (int i = 0; i < T; i++) m_tram[i] = 32'h99000020;
    m_tram[0] = 32'h94000051;
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 15)      u = LF;
      else if (r < 20) u = CR;
      else if (r < 25) u = 21'($urandom_range(32'h110000, 32'h1FFFFF));
      else             u = 21'($urandom_range(32'h21, 32'h7E));
      f = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      model_char(int'(u), int'(f), int'(b));
      send_char(u, f, b, low, base);
      nw = wr_a.size() - base;
      chk($sformatf("r%0d_nwr", n), 32'(nw), 32'(e_a.size()));
      if (nw == e_a.size())
        for (int k = 0; k < nw; k++) begin
          chk($sformatf("r%0d_addr%0d", n, k), 32'(wr_a[base+k]), 32'(e_a[k]));
          chk($sformatf("r%0d_data%0d", n, k), wr_d[base+k], e_d[k]);
        end
      chk($sformatf("r%0d_low", n), 32'(low), 32'(e_low));
      chk($sformatf("r%0d_x", n), 32'(cur_x), 32'(m_x));
      chk($sformatf("r%0d_y", n), 32'(cur_y), 32'(m_y));
      chk($sformatf("r%0d_scroll", n), 32'(scroll_offs), 32'(m_s));
    end
    for (int i = 0; i < T; i++) chk($sformatf("tram%0d", i), dut_tram[i], m_tram[i]);

    // Reset asserted in the middle of a full clear
    @(negedge clk); #1; clear = 1'b1;
    @(negedge clk); #1; clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_pre_we", 32'(tram_we), 1);
    #1; rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(tram_we), 0);
    chk("arst_scroll", 32'(scroll_offs), 0);
    chk("arst_xy", {16'(cur_x), 16'(cur_y)}, 0);
    chk("arst_ready", 32'(ch_ready), 0);
    @(negedge clk); #1; rst_n = 1'b1;
    #1;
    chk("arst_ready_rise", 32'(ch_ready), 0);
    @(negedge clk);
    chk("arst_ready_after", 32'(ch_ready), 1);
    chk("arst_we_after", 32'(tram_we), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
